// File: rtl/wave_ui_pkg.sv
// Shared constants for the scope front-panel controller: key indices and
// acquisition state encodings.
package wave_ui_pkg;

    localparam int N_KEY     = 6;
    localparam int KEY_MODE  = 0;
    localparam int KEY_ARM   = 1;
    localparam int KEY_EDGE  = 2;
    localparam int KEY_CHSEL = 3;
    localparam int KEY_UP    = 4;
    localparam int KEY_DOWN  = 5;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: two-flop synchroniser, stable-count debounce and a
// registered one-cycle press pulse on each accepted 1->0 transition.
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_state,
    output logic key_press
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             state_prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            key_state  <= 1'b1;
            state_prev <= 1'b1;
            key_press  <= 1'b0;
            cnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge value, which is what makes the sync chain two flops deep.
            sync1      <= key_raw;
            sync2      <= sync1;
            state_prev <= key_state;
            key_press  <= state_prev & ~key_state;
            if (sync2 == key_state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_state <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_ui_ctrl.sv
// Front-panel UI state: run/single FSM, trigger edge, channel select and
// per-channel trigger levels with auto-repeat on the UP/DOWN keys.
module wave_ui_ctrl
    import wave_ui_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int LVL_W      = 8,
    parameter int LVL_INIT   = 128,
    parameter int DEB_CYCLES = 500000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_KEY-1:0]          key_in,
    input  logic                      frame_done,
    output logic                      capture_en,
    output logic [1:0]                run_state,
    output logic                      single_mode,
    output logic                      trig_edge,
    output logic [$clog2(NUM_CH):0]   ch_sel,
    output logic [NUM_CH*LVL_W-1:0]   trig_level,
    output logic [N_KEY-1:0]          key_press
);

    localparam int               SEL_W       = $clog2(NUM_CH) + 1;
    localparam int               HOLD_W      = $clog2(RPT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RPT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RPT_DELAY - RPT_PERIOD);
    localparam logic [SEL_W-1:0]  SEL_LAST    = SEL_W'(NUM_CH - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX     = '1;
    localparam logic [LVL_W-1:0]  LVL_RST     = LVL_W'(LVL_INIT);

    logic [N_KEY-1:0]  key_state;
    logic              unused_key_state;
    logic [1:0]        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              step_up;
    logic              step_dn;
    logic [LVL_W-1:0]  lvl [NUM_CH];

    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .key_raw  (key_in[k]),
            .key_state(key_state[k]),
            .key_press(key_press[k])
        );
    end

    // Only the level keys need their held state; the others act on presses.
    assign unused_key_state = &key_state[KEY_CHSEL:KEY_MODE];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lvl_out
        assign trig_level[c*LVL_W +: LVL_W] = lvl[c];
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = run_state;
        case (run_state)
            ST_RUN: begin
                if (key_press[KEY_MODE]) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (key_press[KEY_MODE]) state_nxt = ST_RUN;
                else if (frame_done)     state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (key_press[KEY_MODE])     state_nxt = ST_RUN;
                else if (key_press[KEY_ARM]) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Reloading to RPT_DELAY-RPT_PERIOD reuses one terminal count for both
    // the initial delay and the repeat period, so the counter never wraps.
    always_comb begin
        step_up  = 1'b0;
        step_dn  = 1'b0;
        hold_nxt = '0;
        if (key_state[KEY_UP] || key_state[KEY_DOWN]) begin
            if (key_press[KEY_UP]) begin
                step_up = 1'b1;
            end else if (key_press[KEY_DOWN]) begin
                step_dn = 1'b1;
            end else if (!key_state[KEY_UP] || !key_state[KEY_DOWN]) begin
                if (hold_cnt == HOLD_LAST) begin
                    step_up  = !key_state[KEY_UP];
                    step_dn  = !key_state[KEY_DOWN];
                    hold_nxt = HOLD_RELOAD;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_state   <= ST_RUN;
            capture_en  <= 1'b1;
            single_mode <= 1'b0;
            trig_edge   <= 1'b0;
            ch_sel      <= '0;
            hold_cnt    <= '0;
            // NOTE: the level array is ordinary registers, so it resets like any other state.
            for (int c = 0; c < NUM_CH; c++) lvl[c] <= LVL_RST;
        end else begin
            run_state   <= state_nxt;
            capture_en  <= (state_nxt != ST_HOLD);
            single_mode <= (state_nxt != ST_RUN);
            hold_cnt    <= hold_nxt;
            if (key_press[KEY_EDGE]) trig_edge <= ~trig_edge;
            if (key_press[KEY_CHSEL]) ch_sel <= (ch_sel == SEL_LAST) ? '0 : ch_sel + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == SEL_W'(c)) begin
                    if (step_up && lvl[c] != LVL_MAX)     lvl[c] <= lvl[c] + 1'b1;
                    else if (step_dn && lvl[c] != '0)     lvl[c] <= lvl[c] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_ui_ctrl.sv
// Directed bench for wave_ui_ctrl with short debounce/repeat timings; all
// expected values are hand-derived from the cycle timing of the key path.
module tb_wave_ui_ctrl;
    import wave_ui_pkg::*;

    localparam int NUM_CH     = 3;
    localparam int LVL_W      = 4;
    localparam int LVL_INIT   = 8;
    localparam int DEB_CYCLES = 4;
    localparam int RPT_DELAY  = 20;
    localparam int RPT_PERIOD = 5;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [N_KEY-1:0]        key_in = '1;
    logic                    frame_done = 1'b0;
    logic                    capture_en;
    logic [1:0]              run_state;
    logic                    single_mode;
    logic                    trig_edge;
    logic [2:0]              ch_sel;
    logic [NUM_CH*LVL_W-1:0] trig_level;
    logic [N_KEY-1:0]        key_press;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    wave_ui_ctrl #(
        .NUM_CH(NUM_CH), .LVL_W(LVL_W), .LVL_INIT(LVL_INIT),
        .DEB_CYCLES(DEB_CYCLES), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_in(key_in), .frame_done(frame_done),
        .capture_en(capture_en), .run_state(run_state), .single_mode(single_mode),
        .trig_edge(trig_edge), .ch_sel(ch_sel), .trig_level(trig_level),
        .key_press(key_press)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_count(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            step(1);
            if (key_press != '0) pulses++;
        end
    endtask

    // A key driven low after edge t pulses key_press after edge t+7 (DEB+3).
    task automatic key_down(input int k);
        key_in[k] = 1'b0;
        step(DEB_CYCLES + 3);
    endtask

    task automatic key_up(input int k);
        key_in[k] = 1'b1;
        step(DEB_CYCLES + 4);
    endtask

    task automatic tap(input int k);
        key_down(k);
        step(1);
        key_up(k);
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        step(1);
        frame_done = 1'b0;
        step(1);
    endtask

    function automatic int unsigned lvl(input int c);
        return trig_level[c*LVL_W +: LVL_W];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_run_state"}, run_state, 0);
        check({tag, "_capture_en"}, capture_en, 1);
        check({tag, "_single_mode"}, single_mode, 0);
        check({tag, "_trig_edge"}, trig_edge, 0);
        check({tag, "_ch_sel"}, ch_sel, 0);
        check({tag, "_trig_level"}, trig_level, 12'h888);
        check({tag, "_key_press"}, key_press, 0);
    endtask

    initial begin
        step(3);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        step(2);

        // 1: short glitch, then a clean press on EDGE
        key_in[KEY_EDGE] = 1'b0;
        step(3);
        key_in[KEY_EDGE] = 1'b1;
        step_count(12, n);
        check("glitch_pulses", n, 0);
        check("glitch_edge", trig_edge, 0);
        key_in[KEY_EDGE] = 1'b0;
        step_count(DEB_CYCLES + 2, n);
        check("edge_early_pulses", n, 0);
        step(1);
        check("edge_press_pulse", key_press, 6'b000100);
        check("edge_not_yet", trig_edge, 0);
        step(1);
        check("edge_toggled", trig_edge, 1);
        check("edge_pulse_gone", key_press, 0);
        step(2);
        key_in[KEY_EDGE] = 1'b1;
        step_count(10, n);
        check("release_pulses", n, 0);
        check("edge_kept", trig_edge, 1);

        // 2: run/single sequence
        tap(KEY_MODE);
        check("seq_armed", run_state, 1);
        check("seq_armed_cap", capture_en, 1);
        check("seq_armed_single", single_mode, 1);
        pulse_frame();
        check("seq_hold", run_state, 2);
        check("seq_hold_cap", capture_en, 0);
        pulse_frame();
        check("hold_ignores_frame", run_state, 2);
        tap(KEY_ARM);
        check("seq_rearmed", run_state, 1);
        check("seq_rearmed_cap", capture_en, 1);
        pulse_frame();
        check("seq_hold2", run_state, 2);
        check("seq_hold2_cap", capture_en, 0);
        tap(KEY_MODE);
        check("seq_run", run_state, 0);
        check("seq_run_cap", capture_en, 1);
        check("seq_run_single", single_mode, 0);
        tap(KEY_ARM);
        check("arm_in_run", run_state, 0);
        pulse_frame();
        check("frame_in_run", run_state, 0);

        // 3: MODE and frame_done in the same cycle while ARMED
        tap(KEY_MODE);
        check("coinc_armed", run_state, 1);
        key_down(KEY_MODE);
        frame_done = 1'b1;
        step(1);
        frame_done = 1'b0;
        check("coinc_run", run_state, 0);
        check("coinc_cap", capture_en, 1);
        key_up(KEY_MODE);
        check("coinc_stays_run", run_state, 0);

        // 4: channel select wrap, then UP auto-repeat on channel 1
        tap(KEY_CHSEL); check("chsel_1", ch_sel, 1);
        tap(KEY_CHSEL); check("chsel_2", ch_sel, 2);
        tap(KEY_CHSEL); check("chsel_0", ch_sel, 0);
        tap(KEY_CHSEL); check("chsel_1b", ch_sel, 1);
        key_down(KEY_UP);
        step(1);
        check("up_press_ch1", lvl(1), 9);
        check("up_press_ch0", lvl(0), 8);
        check("up_press_ch2", lvl(2), 8);
        step(RPT_DELAY - 1);
        check("up_before_delay", lvl(1), 9);
        step(1);
        check("up_at_delay", lvl(1), 10);
        step(RPT_PERIOD - 1);
        check("up_before_period", lvl(1), 10);
        step(1);
        check("up_at_period", lvl(1), 11);
        // Debounced release lands 6 edges later, so the step at +30 still fires.
        key_up(KEY_UP);
        check("up_after_release", lvl(1), 12);
        check("up_other_ch0", lvl(0), 8);
        check("up_other_ch2", lvl(2), 8);

        // 5: saturation on channel 0, and UP+DOWN together
        tap(KEY_CHSEL); check("chsel_2c", ch_sel, 2);
        tap(KEY_CHSEL); check("chsel_0c", ch_sel, 0);
        key_down(KEY_UP);
        step(200);
        check("sat_max", lvl(0), 15);
        key_up(KEY_UP);
        check("sat_max_kept", lvl(0), 15);
        key_down(KEY_DOWN);
        step(200);
        check("sat_min", lvl(0), 0);
        key_up(KEY_DOWN);
        check("sat_min_kept", lvl(0), 0);
        key_in[KEY_UP]   = 1'b0;
        key_in[KEY_DOWN] = 1'b0;
        step(60);
        key_in[KEY_UP]   = 1'b1;
        key_in[KEY_DOWN] = 1'b1;
        step(DEB_CYCLES + 4);
        check("both_no_step", lvl(0), 0);
        check("both_ch1", lvl(1), 12);
        check("both_ch2", lvl(2), 8);

        // 6: reset during HOLD and auto-repeat
        tap(KEY_MODE);
        pulse_frame();
        check("pre_rst_hold", run_state, 2);
        key_down(KEY_UP);
        step(1);
        check("pre_rst_press", lvl(0), 1);
        step(RPT_DELAY + 2);
        check("pre_rst_repeat", lvl(0), 2);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        key_in = '1;
        step(3);
        reset_n = 1'b1;
        step_count(20, n);
        check("post_rst_pulses", n, 0);
        check("post_rst_level", trig_level, 12'h888);
        tap(KEY_EDGE);
        check("post_rst_edge", trig_edge, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
